dma_mem_arbiter: RTL and testbench
==================================

Name: dma_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the two DMA channels (ch0, ch1).
- Each channel issues one read or write beat per request through a req/gnt handshake.
- Arbitration is round-robin, with optional channel burst lock bounded by MAX_BURST.
- Read data returns one cycle after the accepted read beat and is routed back to the issuing channel.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 16, memory data width
MAX_BURST, 4, max consecutive locked beats for one channel while the other is waiting (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
req0  in  1  ch0 beat request
lock0  in  1  ch0 requests to keep ownership after this beat
we0  in  1  ch0 write(1)/read(0)
addr0  in  ADDR_W  ch0 address
wdata0  in  DATA_W  ch0 write data
gnt0  out  1  ch0 beat accepted this cycle
rvalid0  out  1  ch0 read data valid
rdata0  out  DATA_W  ch0 read data
req1, lock1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as ch0 for ch1
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- One clock (clk); reset is asynchronous and active-high (reset).
- Reset values:
  - gnt0/1=0, rvalid0/1=0, mem_en=0, mem_we=0.
  - mem_addr/mem_wdata=0; rdata0/1=0.
  - last-winner pointer=ch1, so ch0 wins the first contention.
  - owner=NONE, burst_cnt=0, rd_pend=0.
- Handshake:
  - A channel holds req/we/addr/wdata stable until it sees gnt.
  - A beat is accepted in the cycle where reqN && gntN.
  - At most one gnt per cycle. gnt is combinational from req plus registered state (zero-latency grant), forced 0 while reset is high.
- Memory mux:
  - mem_en = gnt0|gnt1.
  - mem_we/mem_addr/mem_wdata come from the granted channel.
  - With no grant: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
- States: IDLE (owner NONE), OWN0, OWN1.
  - IDLE:
    - single requester is granted;
    - both requesting: the channel that is not the last winner is granted.
  - Accepted beat with lockN=1:
    - go to OWNn;
    - burst_cnt increments, saturating at MAX_BURST.
  - Accepted beat with lockN=0: go to IDLE, burst_cnt=0.
  - OWNn:
    - only chN may be granted while chN requests;
    - chN deasserts req, or the other channel waits while burst_cnt==MAX_BURST: release, so the other channel is granted that same cycle and the owner changes, burst_cnt restarts from that beat.
    - with the other channel idle, the lock holds indefinitely.
- Last-winner pointer updates on every accepted beat.
- Read return:
  - Accepted read sets rd_pend and an owner tag.
  - Next cycle rvalidN=1 for the tagged channel only; rdataN captures mem_rdata that cycle and holds it otherwise.
  - Back-to-back reads from alternating channels produce back-to-back rvalids, each to the correct channel.
- Writes produce no response.
- Simultaneous requests in the same cycle are resolved only by the state and pointer rules above; no request is lost, only deferred.
- Reset mid-operation: a pending rvalid is dropped and any lock is cleared; the requester must reissue.
- The arbiter provides no address-conflict checking.

Optional Feature:
- DMA_ARB_PERF_EN:
  - Defined: adds outputs gnt_cnt0, gnt_cnt1 and wait_cnt (16 bits each).
    - gnt_cntN counts accepted beats per channel.
    - wait_cnt counts cycles where any req was asserted without its gnt.
    - All counters wrap at 16'hFFFF->0 and reset to 0.
  - Not defined: ports and logic are absent; arbitration is identical.

Decomposition:
- Shared package dma_pkg:
  - state encodings IDLE/OWN0/OWN1;
  - channel ID constants CH0=0, CH1=1;
  - default ADDR_W=8, DATA_W=16.
- One sub-module, dma_arb_perf: counter bank instantiated only under DMA_ARB_PERF_EN.

Test Plan:
1. Isolated ch0 read of addr 8'h0A with mem[0x0A]=16'h03F2 -> gnt0 same cycle, mem_en=1, mem_we=0; next cycle rvalid0=1, rdata0=16'h03F2, rvalid1=0.
2. req0 and req1 asserted every cycle, lock=0, both reads -> grants alternate 0,1,0,1; rvalid toggles between channels each cycle with the matching data.
3. MAX_BURST=4, lock0=1 with req1 held -> gnt0 for 4 consecutive beats, then gnt1 on cycle 5; ch1 waits exactly 4 cycles.
4. lock1=1 with req0 low for 10 beats -> gnt1 for all 10 beats; req0 rises -> gnt0 after burst_cnt reaches MAX_BURST.
5. ch0 write 16'hBEEF to addr 8'h64, then ch1 read of 8'h64 -> write beat drives mem_we=1, mem_addr=8'h64; the ch1 read returns rdata1=16'hBEEF with no rvalid0.
6. reset asserted the cycle after an accepted read -> rvalid0 never asserts, all outputs read 0; after release, a ch0/ch1 tie grants ch0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the two-channel DMA memory arbiter: owner states,
// channel identifiers and default bus widths.
package dma_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dma_arb_perf.sv
// Free-running performance counters for the arbiter: accepted beats per
// channel and cycles spent with at least one request left ungranted.
module dma_arb_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        beat0,
  input  logic        beat1,
  input  logic        waiting,
  output logic [15:0] gnt_cnt0,
  output logic [15:0] gnt_cnt1,
  output logic [15:0] wait_cnt
);

  // All counters wrap naturally at 16'hFFFF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
      wait_cnt <= '0;
    end else begin
      if (beat0)   gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (beat1)   gnt_cnt1 <= gnt_cnt1 + 16'd1;
      if (waiting) wait_cnt <= wait_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/dma_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between two
// DMA channels, with bounded burst lock. DMA_ARB_PERF_EN adds perf counters.
module dma_mem_arbiter
  import dma_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              lock0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              lock1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMA_ARB_PERF_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
  output logic [15:0]       wait_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              last_reg, last_next;
  logic              rd_pend_reg;
  logic              rd_tag_reg;
  logic [DATA_W-1:0] rdata0_reg, rdata1_reg;

  logic       pick0, pick1;
  logic       beat, beat_ch, beat_lock, beat_we;
  arb_state_t beat_own;

  // Grant selection: an owner keeps the memory unless the other side has
  // waited through a full burst; otherwise round-robin on the last winner.
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    unique case (state_reg)
      OWN0: begin
        if (req0 && !(req1 && cnt_reg == CNT_MAX)) pick0 = 1'b1;
        else if (req1)                             pick1 = 1'b1;
      end
      OWN1: begin
        if (req1 && !(req0 && cnt_reg == CNT_MAX)) pick1 = 1'b1;
        else if (req0)                             pick0 = 1'b1;
      end
      default: begin
        if (req0 && req1) begin
          if (last_reg == CH1) pick0 = 1'b1;
          else                 pick1 = 1'b1;
        end else if (req0) begin
          pick0 = 1'b1;
        end else if (req1) begin
          pick1 = 1'b1;
        end
      end
    endcase
  end

  assign gnt0      = pick0 & ~reset;
  assign gnt1      = pick1 & ~reset;
  assign beat      = gnt0 | gnt1;
  assign beat_ch   = gnt1 ? CH1 : CH0;
  assign beat_lock = gnt1 ? lock1 : lock0;
  assign beat_we   = gnt1 ? we1 : we0;
  assign beat_own  = gnt1 ? OWN1 : OWN0;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    if (beat) begin
      last_next = beat_ch;
      if (beat_lock) begin
        state_next = beat_own;
        // A new owner starts counting from its first beat.
        if (state_reg != beat_own)  cnt_next = CNT_W'(1);
        else if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + CNT_W'(1);
      end else begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      last_reg  <= CH1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    mem_en    = beat;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Read data is passed straight through in its return cycle and held after.
  assign rvalid0 = rd_pend_reg && (rd_tag_reg == CH0);
  assign rvalid1 = rd_pend_reg && (rd_tag_reg == CH1);
  assign rdata0  = rvalid0 ? mem_rdata : rdata0_reg;
  assign rdata1  = rvalid1 ? mem_rdata : rdata1_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_reg <= 1'b0;
      rd_tag_reg  <= CH0;
      rdata0_reg  <= '0;
      rdata1_reg  <= '0;
    end else begin
      rd_pend_reg <= beat & ~beat_we;
      rd_tag_reg  <= beat_ch;
      if (rvalid0) rdata0_reg <= mem_rdata;
      if (rvalid1) rdata1_reg <= mem_rdata;
    end
  end

`ifdef DMA_ARB_PERF_EN
  dma_arb_perf u_perf (
    .clk      (clk),
    .reset    (reset),
    .beat0    (gnt0),
    .beat1    (gnt1),
    .waiting  ((req0 & ~gnt0) | (req1 & ~gnt1)),
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1),
    .wait_cnt (wait_cnt)
  );
`endif

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Directed plus randomized bench for dma_mem_arbiter against a behavioural
// ownership/round-robin model with a shadow memory and read scoreboard.
module tb_dma_mem_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 0, lock0 = 0, we0 = 0, req1 = 0, lock1 = 0, we1 = 0;
  logic [AW-1:0] addr0 = 0, addr1 = 0;
  logic [DW-1:0] wdata0 = 0, wdata1 = 0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
`ifdef DMA_ARB_PERF_EN
  logic [15:0]   gnt_cnt0, gnt_cnt1, wait_cnt;
`endif

  dma_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAX)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMA_ARB_PERF_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .wait_cnt(wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory the arbiter drives, plus an independent shadow copy for expectations.
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  // Model state: who holds the lock, beats in the current burst, last winner.
  int            m_owner = -1;
  int            m_cnt   = 0;
  int            m_last  = 1;
  bit            pend    = 0;
  int            pend_ch = 0;
  logic [DW-1:0] pend_data = '0;
  logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;
  int            m_g = -1;

  int            s_g;
  logic          s_rvalid0, s_rvalid1, s_mem_we;
  logic [DW-1:0] s_rdata0, s_rdata1;
  logic [AW-1:0] s_mem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    if (reset) return -1;
    if (!req0 && !req1) return -1;
    if (req0 && !req1) return 0;
    if (req1 && !req0) return 1;
    if (m_owner == 0) return (m_cnt >= MAX) ? 1 : 0;
    if (m_owner == 1) return (m_cnt >= MAX) ? 0 : 1;
    return 1 - m_last;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = 1; pend = 0; exp_rd0 = '0; exp_rd1 = '0;
  endtask

  // One clock: check every output at the negedge, then advance the model.
  task automatic cycle();
    logic          gwe, glock;
    logic [AW-1:0] gaddr;
    logic [DW-1:0] gwdata;
    @(negedge clk);
    m_g = exp_grant();
    if (pend && pend_ch == 0) exp_rd0 = pend_data;
    if (pend && pend_ch == 1) exp_rd1 = pend_data;
    gwe    = (m_g == 1) ? we1 : we0;
    glock  = (m_g == 1) ? lock1 : lock0;
    gaddr  = (m_g == 1) ? addr1 : addr0;
    gwdata = (m_g == 1) ? wdata1 : wdata0;
    chk("gnt0", gnt0, m_g == 0);
    chk("gnt1", gnt1, m_g == 1);
    chk("mem_en", mem_en, m_g >= 0);
    chk("mem_we", mem_we, (m_g >= 0) ? gwe : 1'b0);
    chk("mem_addr", mem_addr, (m_g >= 0) ? gaddr : '0);
    chk("mem_wdata", mem_wdata, (m_g >= 0) ? gwdata : '0);
    chk("rvalid0", rvalid0, pend && pend_ch == 0);
    chk("rvalid1", rvalid1, pend && pend_ch == 1);
    chk("rdata0", rdata0, exp_rd0);
    chk("rdata1", rdata1, exp_rd1);
    s_g = gnt1 ? 1 : (gnt0 ? 0 : -1);
    s_rvalid0 = rvalid0; s_rvalid1 = rvalid1; s_rdata0 = rdata0; s_rdata1 = rdata1;
    s_mem_we = mem_we; s_mem_addr = mem_addr;
    if (m_g >= 0)
      $display("[TB] %0t ch%0d %s addr=%02h wdata=%04h lock=%0d", $time, m_g,
               gwe ? "WR" : "RD", gaddr, gwdata, glock);
    @(posedge clk);
    #1;
    pend = 0;
    if (m_g >= 0) begin
      if (gwe) ref_mem[gaddr] = gwdata;
      else begin pend = 1; pend_ch = m_g; pend_data = ref_mem[gaddr]; end
      if (glock) begin
        m_cnt   = (m_owner == m_g) ? ((m_cnt < MAX) ? m_cnt + 1 : MAX) : 1;
        m_owner = m_g;
      end else begin
        m_owner = -1; m_cnt = 0;
      end
      m_last = m_g;
    end
  endtask

  task automatic drive0(input logic r, input logic l, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    req0 = r; lock0 = l; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic drive1(input logic r, input logic l, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    req1 = r; lock1 = l; we1 = w; addr1 = a; wdata1 = d;
  endtask

  int t3_exp [5] = '{0, 0, 0, 0, 1};
  int prev_g;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 16'(i * 257) ^ 16'h5A5A;
      mem[i]     = ref_mem[i];
    end
    ref_mem[8'h0A] = 16'h03F2;
    mem[8'h0A]     = 16'h03F2;

    // Reset state, with requests present to show grants are forced low.
    drive0(1, 0, 0, 8'h01, 0); drive1(1, 0, 0, 8'h02, 0);
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
    cycle();

    // 1: isolated ch0 read.
    drive0(1, 0, 0, 8'h0A, 0);
    cycle();
    chk("t1_gnt", s_g, 0);
    drive0(0, 0, 0, 0, 0);
    cycle();
    chk("t1_rvalid0", s_rvalid0, 1);
    chk("t1_rdata0", s_rdata0, 16'h03F2);
    chk("t1_rvalid1", s_rvalid1, 0);

    // 2: both channels reading every cycle, no lock.
    drive0(1, 0, 0, 8'h10, 0); drive1(1, 0, 0, 8'h20, 0);
    cycle();
    prev_g = s_g;
    for (int i = 1; i < 6; i++) begin
      if (prev_g == 0) addr0 = addr0 + 8'd1; else addr1 = addr1 + 8'd1;
      cycle();
      chk("t2_alternate", s_g, 1 - prev_g);
      prev_g = s_g;
    end
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
    cycle();

    // 3: ch0 locked burst against a waiting ch1 (ch1 wins last first).
    drive1(1, 0, 0, 8'h30, 0);
    cycle();
    drive1(0, 0, 0, 0, 0);
    cycle();
    drive0(1, 1, 0, 8'h40, 0); drive1(1, 0, 1, 8'h31, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_burst", s_g, t3_exp[i]);
      if (s_g == 0) addr0 = addr0 + 8'd1;
      if (s_g == 1) drive1(0, 0, 0, 0, 0);
    end
    lock0 = 0;
    cycle();
    drive0(0, 0, 0, 0, 0);
    cycle();

    // 4: ch1 locked with ch0 idle, then ch0 arrives after saturation.
    drive1(1, 1, 0, 8'h50, 0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t4_hold", s_g, 1);
      addr1 = addr1 + 8'd1;
    end
    drive0(1, 0, 0, 8'h60, 0);
    cycle();
    chk("t4_release", s_g, 0);
    drive0(0, 0, 0, 0, 0); lock1 = 0;
    cycle();
    drive1(0, 0, 0, 0, 0);
    cycle();

    // 5: ch0 write then ch1 read of the same address.
    drive0(1, 0, 1, 8'h64, 16'hBEEF);
    cycle();
    chk("t5_we", s_mem_we, 1);
    chk("t5_addr", s_mem_addr, 8'h64);
    drive0(0, 0, 0, 0, 0); drive1(1, 0, 0, 8'h64, 0);
    cycle();
    drive1(0, 0, 0, 0, 0);
    cycle();
    chk("t5_rvalid1", s_rvalid1, 1);
    chk("t5_rdata1", s_rdata1, 16'hBEEF);
    chk("t5_rvalid0", s_rvalid0, 0);

    // Random traffic honouring the hold-until-grant rule.
    for (int i = 0; i < 400; i++) begin
      if (!req0 || m_g == 0)
        drive0(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), 1'($urandom),
               8'($urandom_range(0, 15)), 16'($urandom));
      if (!req1 || m_g == 1)
        drive1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), 1'($urandom),
               8'($urandom_range(0, 15)), 16'($urandom));
      cycle();
    end
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
    cycle();
    cycle();

    // 6: reset right after an accepted read drops the response.
    drive0(1, 1, 0, 8'h0A, 0);
    cycle();
    reset = 1'b1;
    model_reset();
    drive1(1, 0, 0, 8'h0B, 0);
    cycle();
    chk("t6_rvalid0", s_rvalid0, 0);
    chk("t6_rdata0", s_rdata0, 0);
    reset = 1'b0;
    cycle();
    chk("t6_tie", s_g, 0);
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
